// File: rtl/fifo_merge.sv
// Round-robin merger of N_SRC first-word-fall-through word FIFOs into one
// registered FWFT output stage with bounded per-source bursts.
module fifo_merge #(
    parameter int N_SRC     = 2,
    parameter int DSIZE     = 32,
    parameter int SRC_W     = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    input  logic [N_SRC-1:0]         IN_EMPTY,
    input  logic [N_SRC*DSIZE-1:0]   IN_DATA,
    output logic [N_SRC-1:0]         IN_READ,
    input  logic                     OUT_READ,
    output logic                     OUT_EMPTY,
    output logic [DSIZE-1:0]         OUT_DATA,
    output logic [SRC_W-1:0]         OUT_SRC,
    output logic                     READ_ERROR
);

    localparam logic [7:0]       MAX_B    = 8'(MAX_BURST);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_SRC - 1);

    // Handshake: a word is offered while OUT_EMPTY=0 and is consumed on any
    // edge where OUT_READ=1; a source word is taken on any edge where its
    // IN_READ bit is high, which only happens while that source is non-empty.
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] last_src;
    logic [7:0]       burst_cnt;

    logic             load_en;
    logic             keep;
    logic             sel_valid;
    logic [SRC_W-1:0] sel_src;
    logic [SRC_W-1:0] cand;
    logic [DSIZE-1:0] sel_data;

    assign load_en = OUT_EMPTY | OUT_READ;
    assign keep    = (burst_cnt != 8'd0) & ~IN_EMPTY[grant] & (burst_cnt < MAX_B);

    // Scan starts just after the last granted source so an exhausted burst
    // always hands over to the next waiting source before returning.
    always_comb begin
        sel_valid = 1'b0;
        sel_src   = '0;
        cand      = '0;
        if (keep) begin
            sel_valid = 1'b1;
            sel_src   = grant;
        end else begin
            for (int k = 1; k <= N_SRC; k++) begin
                cand = SRC_W'((int'(last_src) + k) % N_SRC);
                if (!sel_valid && !IN_EMPTY[cand]) begin
                    sel_valid = 1'b1;
                    sel_src   = cand;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel_src == SRC_W'(i)) begin
                sel_data = IN_DATA[i*DSIZE +: DSIZE];
            end
        end
    end

    always_comb begin
        IN_READ = '0;
        for (int i = 0; i < N_SRC; i++) begin
            IN_READ[i] = BUS_RST & load_en & sel_valid & (sel_src == SRC_W'(i));
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST) begin
            OUT_EMPTY  <= 1'b1;
            OUT_DATA   <= '0;
            OUT_SRC    <= '0;
            READ_ERROR <= 1'b0;
            grant      <= '0;
            burst_cnt  <= 8'd0;
            last_src   <= LAST_SRC;
        end else begin
            if (OUT_READ && OUT_EMPTY) begin
                READ_ERROR <= 1'b1;
            end
            if (load_en) begin
                if (sel_valid) begin
                    OUT_DATA  <= sel_data;
                    OUT_SRC   <= sel_src;
                    OUT_EMPTY <= 1'b0;
                    if (keep) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end else begin
                        grant     <= sel_src;
                        last_src  <= sel_src;
                        burst_cnt <= 8'd1;
                    end
                end else begin
                    // Idle output: the next word re-arbitrates from last_src+1.
                    OUT_EMPTY <= 1'b1;
                    burst_cnt <= 8'd0;
                end
            end
        end
    end

endmodule
